// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter for async_fifo: turns the rd_en/rd_data/empty port into a valid/ready
// stream through a 2-entry prefetch buffer that tracks the read still in flight.
module async_fifo_rd_stream #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   input  logic                  flush,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [1:0]            level
);

   localparam int unsigned DEPTH = 2;

   logic [1:0]            r_occ;
   logic                  r_inflight;
   logic                  r_drop_pending;
   logic                  r_head;
   logic                  r_tail;
   logic                  r_m_valid;
   logic [DATA_WIDTH-1:0] r_m_data;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_pop;
   logic                  w_capture;
   logic                  w_rd_en;
   logic [2:0]            w_budget;
   logic [1:0]            w_occ_nxt;
   logic                  w_head_nxt;
   logic                  w_tail_nxt;
   logic [DATA_WIDTH-1:0] w_mem_nxt [DEPTH];

   // Words committed after this cycle; a new read is only issued if it is guaranteed a slot.
   assign w_pop     = r_m_valid & m_ready;
   assign w_budget  = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
   assign w_rd_en   = rst_n & ~fifo_empty & ~flush & (w_budget < 3'd2);
   assign w_capture = r_inflight & ~r_drop_pending & ~flush;

   always_comb begin
      w_occ_nxt  = r_occ;
      w_head_nxt = r_head;
      w_tail_nxt = r_tail;
      w_mem_nxt  = r_mem;
      if (flush) begin
         w_occ_nxt  = 2'd0;
         w_head_nxt = 1'b0;
         w_tail_nxt = 1'b0;
      end else begin
         if (w_capture) begin
            w_mem_nxt[r_tail] = fifo_rd_data;
            w_tail_nxt        = ~r_tail;
         end
         if (w_pop) begin
            w_head_nxt = ~r_head;
         end
         w_occ_nxt = r_occ + 2'(w_capture) - 2'(w_pop);
      end
   end

   // m_data is taken from the post-update head so the output is registered yet current.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ          <= 2'd0;
         r_inflight     <= 1'b0;
         r_drop_pending <= 1'b0;
         r_head         <= 1'b0;
         r_tail         <= 1'b0;
         r_m_valid      <= 1'b0;
         r_m_data       <= '0;
         r_mem[0]       <= '0;
         r_mem[1]       <= '0;
      end else begin
         r_occ          <= w_occ_nxt;
         r_inflight     <= w_rd_en;
         r_drop_pending <= flush & r_inflight;
         r_head         <= w_head_nxt;
         r_tail         <= w_tail_nxt;
         r_m_valid      <= (w_occ_nxt != 2'd0);
         r_m_data       <= w_mem_nxt[w_head_nxt];
         r_mem[0]       <= w_mem_nxt[0];
         r_mem[1]       <= w_mem_nxt[1];
      end
   end

   assign fifo_rd_en = w_rd_en;
   assign m_valid    = r_m_valid;
   assign m_data     = r_m_data;
   assign level      = r_occ;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_capture && (r_occ == 2'd2)));

endmodule
